// File: rtl/dma2axi_pkg.sv
// dma2axi_pkg: engine state encodings and AXI field constants for the DMA-to-AXI master bridge.
package dma2axi_pkg;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI_BUS: AXI4 signal bundle with the master-side view used by the bridge.
interface AXI_BUS #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 8
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [2:0]                  aw_prot;
    logic [3:0]                  aw_qos;
    logic [3:0]                  aw_region;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;
    logic [1:0]                  b_resp;
    logic                        b_valid;
    logic                        b_ready;
    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [2:0]                  ar_prot;
    logic [3:0]                  ar_qos;
    logic [3:0]                  ar_region;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_last, r_valid,
        output r_ready
    );
endinterface

// File: rtl/dma2axi_burst_calc.sv
// dma2axi_burst_calc: next burst length (capped by remaining, MAX_BURST and 4 KB page) and the address after it.
module dma2axi_burst_calc
    import dma2axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int MAX_BURST      = 16
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [31:0]               remaining,
    output logic [31:0]               burst_len,
    output logic [AXI_ADDR_WIDTH-1:0] next_addr
);
    localparam int SZ = int'(axi_size(AXI_DATA_WIDTH));

    logic [31:0] to_4k;
    logic [31:0] cap;

    always_comb begin
        to_4k     = (32'd4096 - {20'd0, addr[11:0]}) >> SZ;
        cap       = (to_4k < 32'(MAX_BURST)) ? to_4k : 32'(MAX_BURST);
        burst_len = (remaining < cap) ? remaining : cap;
        next_addr = addr + AXI_ADDR_WIDTH'(burst_len << SZ);
    end

endmodule

// File: rtl/dma2axi_master.sv
// dma2axi_master: independent read and write engines turning DMA control requests into AXI4 INCR bursts.
module dma2axi_master
    import dma2axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 8,
    parameter int MAX_BURST      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    AXI_BUS.Master                    axi_mst,
    input  logic                      dma_read_ctrl_valid,
    output logic                      dma_read_ctrl_ready,
    input  logic [31:0]               dma_read_ctrl_data_index,
    input  logic [31:0]               dma_read_ctrl_data_length,
    input  logic [2:0]                dma_read_ctrl_data_size,
    output logic                      dma_read_chnl_valid,
    input  logic                      dma_read_chnl_ready,
    output logic [AXI_DATA_WIDTH-1:0] dma_read_chnl_data,
    input  logic                      dma_write_ctrl_valid,
    output logic                      dma_write_ctrl_ready,
    input  logic [31:0]               dma_write_ctrl_data_index,
    input  logic [31:0]               dma_write_ctrl_data_length,
    input  logic [2:0]                dma_write_ctrl_data_size,
    input  logic                      dma_write_chnl_valid,
    output logic                      dma_write_chnl_ready,
    input  logic [AXI_DATA_WIDTH-1:0] dma_write_chnl_data,
    output logic                      read_err,
    output logic                      write_err
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int SZ = int'(axi_size(AXI_DATA_WIDTH));

    rd_state_t         rd_state_q, rd_state_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d, rd_next_addr;
    logic [31:0]       rd_rem_q, rd_rem_d, rd_blen;
    logic              rd_err_q, rd_err_d, rd_hs;

    wr_state_t         wr_state_q, wr_state_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d, wr_next_addr;
    logic [31:0]       wr_rem_q, wr_rem_d, wr_blen;
    logic [31:0]       wr_cnt_q, wr_cnt_d;
    logic              wr_err_q, wr_err_d, wr_hs, wr_last;

    logic              unused_size;

    dma2axi_burst_calc #(
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_DATA_WIDTH(AXI_DATA_WIDTH), .MAX_BURST(MAX_BURST)
    ) u_rd_calc (
        .addr(rd_addr_q), .remaining(rd_rem_q), .burst_len(rd_blen), .next_addr(rd_next_addr)
    );

    dma2axi_burst_calc #(
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_DATA_WIDTH(AXI_DATA_WIDTH), .MAX_BURST(MAX_BURST)
    ) u_wr_calc (
        .addr(wr_addr_q), .remaining(wr_rem_q), .burst_len(wr_blen), .next_addr(wr_next_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_rem_q   <= '0;
            rd_err_q   <= 1'b0;
            wr_state_q <= W_IDLE;
            wr_addr_q  <= '0;
            wr_rem_q   <= '0;
            wr_cnt_q   <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_rem_q   <= rd_rem_d;
            rd_err_q   <= rd_err_d;
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_rem_q   <= wr_rem_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_err_q   <= wr_err_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_rem_d   = rd_rem_q;
        rd_hs      = axi_mst.r_valid && dma_read_chnl_ready;
        rd_err_d   = (rd_state_q == R_DATA) && rd_hs && (axi_mst.r_resp != RESP_OKAY);
        unique case (rd_state_q)
            R_IDLE: if (dma_read_ctrl_valid) begin
                rd_addr_d  = AW'({32'd0, dma_read_ctrl_data_index} << SZ);
                rd_rem_d   = dma_read_ctrl_data_length;
                rd_state_d = (dma_read_ctrl_data_length != 32'd0) ? R_ADDR : R_IDLE;
            end
            R_ADDR: rd_state_d = axi_mst.ar_ready ? R_DATA : R_ADDR;
            R_DATA: if (rd_hs && axi_mst.r_last) begin
                rd_rem_d   = rd_rem_q - rd_blen;
                rd_addr_d  = rd_next_addr;
                rd_state_d = (rd_rem_q != rd_blen) ? R_ADDR : R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_rem_d   = wr_rem_q;
        wr_cnt_d   = wr_cnt_q;
        wr_hs      = dma_write_chnl_valid && axi_mst.w_ready;
        wr_last    = wr_cnt_q == (wr_blen - 32'd1);
        wr_err_d   = (wr_state_q == W_RESP) && axi_mst.b_valid && (axi_mst.b_resp != RESP_OKAY);
        unique case (wr_state_q)
            W_IDLE: if (dma_write_ctrl_valid) begin
                wr_addr_d  = AW'({32'd0, dma_write_ctrl_data_index} << SZ);
                wr_rem_d   = dma_write_ctrl_data_length;
                wr_state_d = (dma_write_ctrl_data_length != 32'd0) ? W_ADDR : W_IDLE;
            end
            W_ADDR: wr_state_d = axi_mst.aw_ready ? W_DATA : W_ADDR;
            W_DATA: if (wr_hs) begin
                wr_cnt_d   = wr_last ? 32'd0 : wr_cnt_q + 32'd1;
                wr_state_d = wr_last ? W_RESP : W_DATA;
            end
            W_RESP: if (axi_mst.b_valid) begin
                wr_rem_d   = wr_rem_q - wr_blen;
                wr_addr_d  = wr_next_addr;
                wr_state_d = (wr_rem_q != wr_blen) ? W_ADDR : W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        dma_read_ctrl_ready  = rd_state_q == R_IDLE;
        dma_read_chnl_valid  = (rd_state_q == R_DATA) && axi_mst.r_valid;
        dma_read_chnl_data   = axi_mst.r_data;
        axi_mst.r_ready      = (rd_state_q == R_DATA) && dma_read_chnl_ready;
        axi_mst.ar_valid     = rd_state_q == R_ADDR;
        axi_mst.ar_addr      = rd_addr_q;
        axi_mst.ar_len       = 8'(rd_blen - 32'd1);
        axi_mst.ar_size      = axi_size(AXI_DATA_WIDTH);
        axi_mst.ar_burst     = BURST_INCR;
        axi_mst.ar_id        = AXI_ID_WIDTH'(0);
        axi_mst.ar_user      = AXI_USER_WIDTH'(0);
        axi_mst.ar_lock      = 1'b0;
        axi_mst.ar_cache     = 4'd0;
        axi_mst.ar_prot      = 3'd0;
        axi_mst.ar_qos       = 4'd0;
        axi_mst.ar_region    = 4'd0;
        read_err             = rd_err_q;
        dma_write_ctrl_ready = wr_state_q == W_IDLE;
        dma_write_chnl_ready = (wr_state_q == W_DATA) && axi_mst.w_ready;
        axi_mst.w_valid      = (wr_state_q == W_DATA) && dma_write_chnl_valid;
        axi_mst.w_last       = (wr_state_q == W_DATA) && wr_last;
        axi_mst.w_data       = dma_write_chnl_data;
        axi_mst.w_strb       = '1;
        axi_mst.w_user       = AXI_USER_WIDTH'(0);
        axi_mst.b_ready      = wr_state_q == W_RESP;
        axi_mst.aw_valid     = wr_state_q == W_ADDR;
        axi_mst.aw_addr      = wr_addr_q;
        axi_mst.aw_len       = 8'(wr_blen - 32'd1);
        axi_mst.aw_size      = axi_size(AXI_DATA_WIDTH);
        axi_mst.aw_burst     = BURST_INCR;
        axi_mst.aw_id        = AXI_ID_WIDTH'(0);
        axi_mst.aw_user      = AXI_USER_WIDTH'(0);
        axi_mst.aw_lock      = 1'b0;
        axi_mst.aw_cache     = 4'd0;
        axi_mst.aw_prot      = 3'd0;
        axi_mst.aw_qos       = 4'd0;
        axi_mst.aw_region    = 4'd0;
        write_err            = wr_err_q;
        unused_size          = ^{dma_read_ctrl_data_size, dma_write_ctrl_data_size};
    end

endmodule

// File: tb/tb_dma2axi_master.sv
// tb_dma2axi_master: directed bench acting as AXI slave and DMA initiator around dma2axi_master.
module tb_dma2axi_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dma_read_ctrl_valid = 1'b0, dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index = '0, dma_read_ctrl_data_length = '0;
    logic [2:0]  dma_read_ctrl_data_size = 3'd3;
    logic        dma_read_chnl_valid, dma_read_chnl_ready = 1'b0;
    logic [63:0] dma_read_chnl_data;
    logic        dma_write_ctrl_valid = 1'b0, dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index = '0, dma_write_ctrl_data_length = '0;
    logic [2:0]  dma_write_ctrl_data_size = 3'd3;
    logic        dma_write_chnl_valid = 1'b0, dma_write_chnl_ready;
    logic [63:0] dma_write_chnl_data = '0;
    logic        read_err, write_err;
    int          checks = 0, failures = 0;
    int          rd_err_cnt = 0, wr_err_cnt = 0;
    int          e_r, e_w;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(8)) axi ();

    dma2axi_master #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(8), .MAX_BURST(16)
    ) dut (
        .clk(clk), .rst(rst), .axi_mst(axi),
        .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
        .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
        .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
        .dma_read_chnl_data(dma_read_chnl_data),
        .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
        .dma_write_ctrl_data_index(dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
        .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
        .dma_write_chnl_data(dma_write_chnl_data),
        .read_err(read_err), .write_err(write_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (read_err) rd_err_cnt++;
        if (write_err) wr_err_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_ctrl(input logic [31:0] idx, input logic [31:0] len);
        dma_read_ctrl_valid = 1'b1;
        dma_read_ctrl_data_index = idx;
        dma_read_ctrl_data_length = len;
        for (int c = 0; c < 20 && dma_read_ctrl_ready !== 1'b1; c++) step();
        chk("rd_ctrl_ready", dma_read_ctrl_ready, 1);
        step();
        dma_read_ctrl_valid = 1'b0;
        chk("rd_ctrl_busy", dma_read_ctrl_ready, len == 0);
        chk("ar_valid_next", axi.ar_valid, len != 0);
    endtask

    task automatic wr_ctrl(input logic [31:0] idx, input logic [31:0] len);
        dma_write_ctrl_valid = 1'b1;
        dma_write_ctrl_data_index = idx;
        dma_write_ctrl_data_length = len;
        for (int c = 0; c < 20 && dma_write_ctrl_ready !== 1'b1; c++) step();
        chk("wr_ctrl_ready", dma_write_ctrl_ready, 1);
        step();
        dma_write_ctrl_valid = 1'b0;
        chk("wr_ctrl_busy", dma_write_ctrl_ready, len == 0);
        chk("aw_valid_next", axi.aw_valid, len != 0);
    endtask

    task automatic ar_expect(input logic [31:0] addr, input logic [7:0] len, input int bound, input int hold);
        for (int c = 0; c < bound && axi.ar_valid !== 1'b1; c++) step();
        for (int h = 0; h < hold; h++) step();
        chk("ar_valid", axi.ar_valid, 1);
        chk("ar_addr", axi.ar_addr, addr);
        chk("ar_len", axi.ar_len, len);
        chk("ar_size", axi.ar_size, 3);
        chk("ar_burst", axi.ar_burst, 1);
        axi.ar_ready = 1'b1;
        step();
        axi.ar_ready = 1'b0;
        chk("ar_drop", axi.ar_valid, 0);
    endtask

    task automatic aw_expect(input logic [31:0] addr, input logic [7:0] len, input int bound);
        for (int c = 0; c < bound && axi.aw_valid !== 1'b1; c++) step();
        chk("aw_valid", axi.aw_valid, 1);
        chk("aw_addr", axi.aw_addr, addr);
        chk("aw_len", axi.aw_len, len);
        chk("aw_size", axi.aw_size, 3);
        axi.aw_ready = 1'b1;
        step();
        axi.aw_ready = 1'b0;
        chk("aw_drop", axi.aw_valid, 0);
    endtask

    task automatic rd_burst(input int n, input logic [63:0] base, input bit tog, input bit gaps);
        int i = 0;
        for (int c = 0; c < 400 && i < n; c++) begin
            axi.r_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            dma_read_chnl_ready = tog ? !dma_read_chnl_ready : 1'b1;
            axi.r_data = base + 64'(i);
            axi.r_last = (i == n - 1);
            axi.r_resp = 2'b00;
            #1;
            chk("r_ready", axi.r_ready, dma_read_chnl_ready);
            chk("rd_chnl_valid", dma_read_chnl_valid, axi.r_valid);
            if (axi.r_valid && dma_read_chnl_ready) begin
                chk("rd_data", dma_read_chnl_data, base + 64'(i));
                i++;
            end
            step();
        end
        axi.r_valid = 1'b0;
        axi.r_last = 1'b0;
        dma_read_chnl_ready = 1'b0;
        chk("rd_beats", 64'(i), 64'(n));
    endtask

    task automatic wr_burst(input int n, input logic [63:0] base, input bit gaps);
        int i = 0;
        for (int c = 0; c < 400 && i < n; c++) begin
            dma_write_chnl_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            axi.w_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            dma_write_chnl_data = base + 64'(i);
            #1;
            chk("w_valid", axi.w_valid, dma_write_chnl_valid);
            chk("wr_chnl_ready", dma_write_chnl_ready, axi.w_ready);
            if (dma_write_chnl_valid && axi.w_ready) begin
                chk("w_data", axi.w_data, base + 64'(i));
                chk("w_last", axi.w_last, i == n - 1);
                chk("w_strb", axi.w_strb, 8'hFF);
                i++;
            end
            step();
        end
        dma_write_chnl_valid = 1'b0;
        axi.w_ready = 1'b0;
        chk("wr_beats", 64'(i), 64'(n));
    endtask

    task automatic b_send(input logic [1:0] resp);
        for (int c = 0; c < 5 && axi.b_ready !== 1'b1; c++) step();
        chk("b_ready", axi.b_ready, 1);
        axi.b_valid = 1'b1;
        axi.b_resp = resp;
        step();
        axi.b_valid = 1'b0;
        axi.b_resp = 2'b00;
        chk("b_ready_drop", axi.b_ready, 0);
    endtask

    initial begin
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0; axi.b_resp = 2'b00;
        axi.ar_ready = 1'b0; axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = 2'b00; axi.r_last = 1'b0;
        repeat (3) step();
        chk("rst_rd_ctrl_ready", dma_read_ctrl_ready, 1);
        chk("rst_wr_ctrl_ready", dma_write_ctrl_ready, 1);
        chk("rst_ar_valid", axi.ar_valid, 0);
        chk("rst_aw_valid", axi.aw_valid, 0);
        chk("rst_w_valid", axi.w_valid, 0);
        chk("rst_w_last", axi.w_last, 0);
        chk("rst_b_ready", axi.b_ready, 0);
        chk("rst_r_ready", axi.r_ready, 0);
        chk("rst_errs", {read_err, write_err}, 0);
        chk("rst_ar_addr", axi.ar_addr, 0);
        chk("rst_aw_addr", axi.aw_addr, 0);
        rst = 1'b0;
        step();

        rd_ctrl(32'h0, 32'd4);
        ar_expect(32'h0, 8'd3, 0, 2);
        rd_burst(4, 64'hA000, 1'b0, 1'b0);
        chk("t1_rd_idle", dma_read_ctrl_ready, 1);

        wr_ctrl(32'h10, 32'd40);
        aw_expect(32'h80, 8'd15, 0);
        wr_burst(16, 64'h1000, 1'b0);
        b_send(2'b00);
        aw_expect(32'h100, 8'd15, 0);
        wr_burst(16, 64'h2000, 1'b0);
        b_send(2'b00);
        aw_expect(32'h180, 8'd7, 0);
        wr_burst(8, 64'h3000, 1'b0);
        b_send(2'b00);
        chk("t2_wr_idle", dma_write_ctrl_ready, 1);
        chk("t2_aw_idle", axi.aw_valid, 0);

        rd_ctrl(32'h1FC, 32'd8);
        ar_expect(32'hFE0, 8'd3, 0, 0);
        rd_burst(4, 64'hB000, 1'b0, 1'b0);
        ar_expect(32'h1000, 8'd3, 0, 0);
        rd_burst(4, 64'hB004, 1'b0, 1'b0);
        chk("t3_rd_idle", dma_read_ctrl_ready, 1);

        rd_ctrl(32'h20, 32'd16);
        ar_expect(32'h100, 8'd15, 0, 0);
        rd_burst(16, 64'hC000, 1'b1, 1'b1);
        chk("t4_rd_idle", dma_read_ctrl_ready, 1);

        e_r = rd_err_cnt;
        e_w = wr_err_cnt;
        fork
            begin
                rd_ctrl(32'h40, 32'd16);
                ar_expect(32'h200, 8'd15, 5, 0);
                rd_burst(16, 64'hD000, 1'b0, 1'b1);
            end
            begin
                wr_ctrl(32'h80, 32'd16);
                aw_expect(32'h400, 8'd15, 5);
                wr_burst(16, 64'hE000, 1'b1);
                b_send(2'b10);
            end
        join
        step();
        step();
        chk("t5_write_err_pulses", 64'(wr_err_cnt - e_w), 1);
        chk("t5_read_err_pulses", 64'(rd_err_cnt - e_r), 0);
        chk("t5_rd_idle", dma_read_ctrl_ready, 1);
        chk("t5_wr_idle", dma_write_ctrl_ready, 1);

        rd_ctrl(32'h5, 32'd0);
        wr_ctrl(32'h5, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("len0_ar_valid", axi.ar_valid, 0);
            chk("len0_aw_valid", axi.aw_valid, 0);
        end

        wr_ctrl(32'h0, 32'd8);
        aw_expect(32'h0, 8'd7, 0);
        dma_write_chnl_valid = 1'b1;
        axi.w_ready = 1'b1;
        repeat (3) step();
        chk("mid_w_valid", axi.w_valid, 1);
        rst = 1'b1;
        step();
        chk("rst_mid_w_valid", axi.w_valid, 0);
        chk("rst_mid_wr_chnl_ready", dma_write_chnl_ready, 0);
        chk("rst_mid_aw_valid", axi.aw_valid, 0);
        chk("rst_mid_b_ready", axi.b_ready, 0);
        chk("rst_mid_w_last", axi.w_last, 0);
        chk("rst_mid_wr_ctrl_ready", dma_write_ctrl_ready, 1);
        chk("rst_mid_rd_ctrl_ready", dma_read_ctrl_ready, 1);
        rst = 1'b0;
        dma_write_chnl_valid = 1'b0;
        axi.w_ready = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
